// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared encodings for the data RAM arbiter
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// rtl/ram_arbiter_arb_pick.sv - winner select and VGA streak counter
module arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cpu_req,
  input  logic i_vga_req,
  input  logic i_arb_en,
  output logic o_grant_vga
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic       w_grant_vga;

  // VGA wins unless it has starved a waiting CPU for STREAK_MAX grants in a row
  always_comb begin
    w_grant_vga = i_vga_req && !(i_cpu_req && (r_streak == STREAK_MAX));
  end

  // Count VGA grants taken while the CPU is waiting; any other arbitration clears
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_streak <= 4'd0;
    end else if (i_arb_en) begin
      if (!w_grant_vga || !i_cpu_req) begin
        r_streak <= 4'd0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  assign o_grant_vga = w_grant_vga;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the data RAM between the CPU and the VGA reader
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int VGA_MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ready,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic [3:0]        r_ram_be;
  logic              r_cpu_ready;
  logic              r_vga_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_vga_rdata;
  logic              w_arb_en;
  logic              w_grant_vga;

  assign w_arb_en = (r_state == ST_IDLE) && (cpu_req || vga_req);

  arb_pick #(
    .MAX_STREAK (VGA_MAX_STREAK)
  ) u_pick (
    .i_clk       (clk),
    .i_rst       (RST),
    .i_cpu_req   (cpu_req),
    .i_vga_req   (vga_req),
    .i_arb_en    (w_arb_en),
    .o_grant_vga (w_grant_vga)
  );

  // State register
  always_ff @(posedge clk) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: writes skip CAPTURE since there is no data to return
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (cpu_req || vga_req) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = r_ram_we ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Datapath: load RAM command on grant, capture read data, raise ready entering DONE
  always_ff @(posedge clk) begin
    if (RST) begin
      r_owner     <= OWN_CPU;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= 4'b0000;
      r_cpu_ready <= 1'b0;
      r_vga_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_vga_rdata <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_vga_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_en) begin
            if (w_grant_vga) begin
              r_owner     <= OWN_VGA;
              r_ram_addr  <= vga_addr;
              r_ram_wdata <= '0;
              r_ram_we    <= 1'b0;
              r_ram_be    <= BE_ALL;
            end else begin
              r_owner     <= OWN_CPU;
              r_ram_addr  <= cpu_addr;
              r_ram_wdata <= cpu_wdata;
              r_ram_we    <= cpu_we;
              r_ram_be    <= cpu_be;
            end
          end
        end
        ST_ISSUE: begin
          r_ram_we <= 1'b0;
          if (r_ram_we) begin
            r_cpu_ready <= (r_owner == OWN_CPU);
            r_vga_ready <= (r_owner == OWN_VGA);
          end
        end
        ST_CAPTURE: begin
          if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= ram_rdata;
            r_cpu_ready <= 1'b1;
          end else begin
            r_vga_rdata <= ram_rdata;
            r_vga_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign vga_ready = r_vga_ready;
  assign vga_rdata = r_vga_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;

endmodule
